// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI bridge.
package hpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DONE    = 3'd4,
        ST_RECOVER = 3'd5
    } hpi_state_e;

    // HPI register map as seen on A[1:0]
    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDR    = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/hpi_sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module hpi_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/otg_hpi_bridge.sv
// Avalon-MM slave that turns each access into one timed HPI bus cycle
// (setup, strobe, hold, recovery) and synchronises the OTG interrupt.
module otg_hpi_bridge
    import hpi_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              waitrequest,
    output logic [1:0]        otg_addr,
    output logic              otg_cs_n,
    output logic              otg_rd_n,
    output logic              otg_wr_n,
    output logic [DATA_W-1:0] otg_data_out,
    output logic              otg_data_oe,
    input  logic [DATA_W-1:0] otg_data_in,
    input  logic              otg_int,
    output logic              irq
);

    localparam int unsigned MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MAX_HR  = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
    localparam int unsigned MAX_CYC = (MAX_SS > MAX_HR) ? MAX_SS : MAX_HR;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    hpi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              dir_wr_q, dir_wr_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              oe_q, oe_d;
    logic              req_c;
    logic              bus_active_c;

    // Counter preload: remaining cycles minus one for the state being entered
    function automatic logic [CNT_W-1:0] load_cnt(input hpi_state_e s);
        logic [CNT_W-1:0] v;
        v = '0;
        case (s)
            ST_SETUP:   v = CNT_W'(SETUP_CYC - 1);
            ST_STROBE:  v = CNT_W'(STROBE_CYC - 1);
            ST_HOLD:    v = CNT_W'(HOLD_CYC - 1);
            ST_RECOVER: v = (RECOVER_CYC == 0) ? '0 : CNT_W'(RECOVER_CYC - 1);
            default:    v = '0;
        endcase
        return v;
    endfunction

    assign req_c = chipselect & (read | write);

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        dir_wr_d = dir_wr_q;
        rdata_d  = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    state_d  = ST_SETUP;
                    addr_d   = address;
                    wdata_d  = writedata;
                    dir_wr_d = write;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    if (!dir_wr_q) rdata_d = otg_data_in;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = (RECOVER_CYC == 0) ? ST_IDLE : ST_RECOVER;
            end
            ST_RECOVER: begin
                if (cnt_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) cnt_d = load_cnt(state_d);

        // Pins are decoded from the next state so they switch on the entry edge
        bus_active_c = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        cs_n_d       = ~bus_active_c;
        rd_n_d       = ~((state_d == ST_STROBE) && !dir_wr_d);
        wr_n_d       = ~((state_d == ST_STROBE) && dir_wr_d);
        oe_d         = bus_active_c && dir_wr_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            dir_wr_q <= 1'b0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            dir_wr_q <= dir_wr_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            oe_q     <= oe_d;
        end
    end

    assign waitrequest  = (state_q != ST_DONE);
    assign readdata     = rdata_q;
    assign otg_addr     = addr_q;
    assign otg_data_out = wdata_q;
    assign otg_cs_n     = cs_n_q;
    assign otg_rd_n     = rd_n_q;
    assign otg_wr_n     = wr_n_q;
    assign otg_data_oe  = oe_q;

    hpi_sync2 u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d     (otg_int),
        .q     (irq)
    );

endmodule

// File: tb/tb_otg_hpi_bridge.sv
// Directed bench for otg_hpi_bridge: per-cycle pin checks over a transaction table
// plus back-to-back, mid-strobe reset and interrupt-latency sequences.
module tb_otg_hpi_bridge;
    import hpi_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        waitrequest;
    logic [1:0]  otg_addr;
    logic        otg_cs_n;
    logic        otg_rd_n;
    logic        otg_wr_n;
    logic [15:0] otg_data_out;
    logic        otg_data_oe;
    logic [15:0] otg_data_in;
    logic        otg_int;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        cs;
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] pad;
        logic        exp_active;
        logic        exp_wr;
        logic [15:0] exp_rdata;
    } txn_t;

    txn_t tbl [6];

    otg_hpi_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .waitrequest  (waitrequest),
        .otg_addr     (otg_addr),
        .otg_cs_n     (otg_cs_n),
        .otg_rd_n     (otg_rd_n),
        .otg_wr_n     (otg_wr_n),
        .otg_data_out (otg_data_out),
        .otg_data_oe  (otg_data_oe),
        .otg_data_in  (otg_data_in),
        .otg_int      (otg_int),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge; cycle 0 is the IDLE cycle that sees the request
    task automatic run_txn(input int idx, input txn_t t);
        logic in_cs, in_stb;
        chipselect  = t.cs;
        read        = t.rd;
        write       = t.wr;
        address     = t.addr;
        writedata   = t.wdata;
        for (int k = 0; k < 10; k++) begin
            in_cs  = (k >= 1) && (k <= 6);
            in_stb = (k >= 2) && (k <= 5);
            if (k == 3) begin
                address   = ~t.addr;
                writedata = ~t.wdata;
            end
            otg_data_in = (k == 5) ? t.pad : (16'hC000 | 16'(k));
            @(negedge clk);
            check($sformatf("t%0d_k%0d_cs_n", idx, k), 32'(otg_cs_n),
                  32'(!(t.exp_active && in_cs)));
            check($sformatf("t%0d_k%0d_rd_n", idx, k), 32'(otg_rd_n),
                  32'(!(t.exp_active && !t.exp_wr && in_stb)));
            check($sformatf("t%0d_k%0d_wr_n", idx, k), 32'(otg_wr_n),
                  32'(!(t.exp_active && t.exp_wr && in_stb)));
            check($sformatf("t%0d_k%0d_oe", idx, k), 32'(otg_data_oe),
                  32'(t.exp_active && t.exp_wr && in_cs));
            check($sformatf("t%0d_k%0d_waitreq", idx, k), 32'(waitrequest),
                  32'(!(t.exp_active && k == 7)));
            if (t.exp_active && in_cs)
                check($sformatf("t%0d_k%0d_addr", idx, k), 32'(otg_addr), 32'(t.addr));
            if (t.exp_active && t.exp_wr && in_cs)
                check($sformatf("t%0d_k%0d_dout", idx, k), 32'(otg_data_out), 32'(t.wdata));
            if (k == 7)
                check($sformatf("t%0d_readdata", idx), 32'(readdata), 32'(t.exp_rdata));
            @(posedge clk);
            #1;
            if (k == 7) begin
                chipselect = 1'b0;
                read       = 1'b0;
                write      = 1'b0;
            end
        end
    endtask

    txn_t tr;
    int   cyc;
    int   fall1;
    int   fall2;
    int   last_low;
    int   dones;
    int   lat;
    logic prev_cs_n;

    initial begin
        //            cs    rd    wr    addr        wdata     pad       act   wr    rdata
        tbl[0] = '{1'b1, 1'b0, 1'b1, HPI_ADDR,    16'h1234, 16'h0000, 1'b1, 1'b1, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 1'b0, HPI_DATA,    16'h0000, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF};
        tbl[2] = '{1'b1, 1'b1, 1'b1, HPI_MAILBOX, 16'h5A5A, 16'h7777, 1'b1, 1'b1, 16'hBEEF};
        tbl[3] = '{1'b0, 1'b1, 1'b0, HPI_STATUS,  16'h0000, 16'h1111, 1'b0, 1'b0, 16'hBEEF};
        tbl[4] = '{1'b1, 1'b1, 1'b0, HPI_STATUS,  16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0001};
        tbl[5] = '{1'b1, 1'b0, 1'b1, HPI_DATA,    16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0001};

        reset       = 1'b1;
        address     = 2'd0;
        chipselect  = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        writedata   = 16'h0;
        otg_data_in = 16'h0;
        otg_int     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_cs_n",  32'(otg_cs_n), 32'd1);
        check("rst_rd_n",  32'(otg_rd_n), 32'd1);
        check("rst_wr_n",  32'(otg_wr_n), 32'd1);
        check("rst_oe",    32'(otg_data_oe), 32'd0);
        check("rst_addr",  32'(otg_addr), 32'd0);
        check("rst_dout",  32'(otg_data_out), 32'd0);
        check("rst_rdata", 32'(readdata), 32'd0);
        check("rst_irq",   32'(irq), 32'd0);
        check("rst_wait",  32'(waitrequest), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_txn(i, tbl[i]);

        // Reset asserted while the strobe is active
        chipselect  = 1'b1;
        read        = 1'b1;
        address     = HPI_DATA;
        otg_data_in = 16'h9999;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("pre_rst_rd_n", 32'(otg_rd_n), 32'd0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
        @(negedge clk);
        check("mid_rst_cs_n",  32'(otg_cs_n), 32'd1);
        check("mid_rst_rd_n",  32'(otg_rd_n), 32'd1);
        check("mid_rst_wr_n",  32'(otg_wr_n), 32'd1);
        check("mid_rst_oe",    32'(otg_data_oe), 32'd0);
        check("mid_rst_wait",  32'(waitrequest), 32'd1);
        check("mid_rst_rdata", 32'(readdata), 32'd0);
        @(posedge clk);
        #1;
        tr = '{1'b1, 1'b1, 1'b0, HPI_MAILBOX, 16'h0000, 16'h3C3C, 1'b1, 1'b0, 16'h3C3C};
        run_txn(10, tr);

        // Back-to-back writes with the request held asserted
        chipselect = 1'b1;
        write      = 1'b1;
        address    = HPI_ADDR;
        writedata  = 16'hA5A5;
        fall1      = -1;
        fall2      = -1;
        last_low   = -1;
        dones      = 0;
        prev_cs_n  = 1'b1;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (!otg_cs_n && prev_cs_n) begin
                if (fall1 < 0) fall1 = cyc;
                else if (fall2 < 0) fall2 = cyc;
            end
            if (!otg_cs_n && fall2 < 0) last_low = cyc;
            prev_cs_n = otg_cs_n;
            if (!waitrequest) dones++;
            @(posedge clk);
            #1;
            if (dones == 2) break;
        end
        chipselect = 1'b0;
        write      = 1'b0;
        check("b2b_done_count", 32'(dones), 32'd2);
        check("b2b_first_setup", 32'(fall1), 32'd1);
        check("b2b_second_setup", 32'(fall2), 32'd11);
        n_cmp++;
        if (fall2 - last_low - 1 < 3) begin
            n_bad++;
            $display("FAIL b2b_cs_high_gap: got %0d cycles expected at least 3",
                     fall2 - last_low - 1);
        end
        repeat (4) @(posedge clk);
        #1;

        // Interrupt synchroniser latency in both directions
        otg_int = 1'b1;
        lat     = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (irq) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if (lat < 2 || lat > 3) begin
            n_bad++;
            $display("FAIL irq_rise_latency: got %0d cycles expected 2..3", lat);
        end
        @(posedge clk);
        #1;
        otg_int = 1'b0;
        lat     = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!irq) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if (lat < 2 || lat > 3) begin
            n_bad++;
            $display("FAIL irq_fall_latency: got %0d cycles expected 2..3", lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
